// File: rtl/rs232_avs_responder.sv
// rtl/rs232_avs_responder.sv - Avalon-MM responder modelling the RS232 UART RX/TX/STATUS map
// Host bytes feed RX reads; TX writes are emitted on the host side.
module rs232_avs_responder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic [31:0] avm_readdata,
  output logic        avm_waitrequest,
  input  logic [7:0]  rx_in_data,
  input  logic        rx_in_valid,
  output logic        rx_in_ready,
  output logic [7:0]  tx_out_data,
  output logic        tx_out_valid,
  input  logic        tx_out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0] ADDR_RX     = 5'h00;
  localparam logic [4:0] ADDR_TX     = 5'h04;
  localparam logic [4:0] ADDR_STATUS = 5'h08;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [4:0]  lat_addr;
  logic        lat_write;
  logic [7:0]  lat_data;
  logic [4:0]  acc_addr;
  logic        acc_write;
  logic        req, entering_ack, in_ack;
  logic        ack_rx_pop;
  logic [31:0] rd_value;
  logic [7:0]  status_byte;
  logic        tx_ovf, rx_unf;

  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [AW:0] rx_count;
  logic        rx_empty, rx_full, rx_push, rx_pop;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [AW:0] tx_count;
  logic        tx_full, tx_push_req, tx_push, tx_pop;

  logic        unused_wdata;
  assign unused_wdata = ^avm_writedata[31:8];

  assign req             = avm_read | avm_write;
  assign in_ack          = (state == ST_ACK);
  assign avm_waitrequest = ~in_ack;
  assign entering_ack    = (state_nxt == ST_ACK);

  // In IDLE the live bus is decoded so a zero-wait access can enter ACK directly.
  always_comb begin
    acc_addr  = lat_addr;
    acc_write = lat_write;
    if (state == ST_IDLE) begin
      acc_addr  = avm_address;
      acc_write = avm_write;
    end
  end

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = ST_ACK;
          end else begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) state_nxt = ST_ACK;
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rx_empty    = (rx_count == '0);
  assign rx_full     = (rx_count == FULL_COUNT);
  assign tx_full     = (tx_count == FULL_COUNT);
  assign status_byte = {~rx_empty, ~tx_full, 1'b0, tx_ovf, rx_unf, 3'b000};

  always_comb begin
    rd_value = 32'h0;
    if (!acc_write) begin
      if (acc_addr == ADDR_RX && !rx_empty) rd_value = {24'h0, rx_mem[rx_rd_ptr]};
      else if (acc_addr == ADDR_STATUS)     rd_value = {24'h0, status_byte};
    end
  end

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      lat_addr     <= 5'h0;
      lat_write    <= 1'b0;
      lat_data     <= 8'h0;
      avm_readdata <= 32'h0;
      ack_rx_pop   <= 1'b0;
    end else begin
      if (state == ST_IDLE && req) begin
        lat_addr  <= avm_address;
        lat_write <= avm_write;
        lat_data  <= avm_writedata[7:0];
      end
      // Only the bus pops RX, so non-empty at ACK entry still holds at the commit edge.
      if (entering_ack) begin
        avm_readdata <= rd_value;
        ack_rx_pop   <= !acc_write && (acc_addr == ADDR_RX) && !rx_empty;
      end else begin
        avm_readdata <= 32'h0;
        ack_rx_pop   <= 1'b0;
      end
    end
  end

  assign rx_pop      = in_ack & ack_rx_pop;
  assign rx_in_ready = ~rx_full | rx_pop;
  assign rx_push     = rx_in_valid & rx_in_ready;

  assign tx_out_valid = (tx_count != '0);
  assign tx_out_data  = tx_out_valid ? tx_mem[tx_rd_ptr] : 8'h00;
  assign tx_pop       = tx_out_valid & tx_out_ready;
  assign tx_push_req  = in_ack & lat_write & (lat_addr == ADDR_TX);
  assign tx_push      = tx_push_req & (~tx_full | tx_pop);

  always_ff @(posedge avm_clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_in_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= lat_data;
  end

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      tx_ovf    <= 1'b0;
      rx_unf    <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase

      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase

      if (in_ack && lat_write && lat_addr == ADDR_STATUS) begin
        tx_ovf <= 1'b0;
        rx_unf <= 1'b0;
      end else begin
        if (tx_push_req && tx_full && !tx_pop) tx_ovf <= 1'b1;
        if (in_ack && !lat_write && lat_addr == ADDR_RX && !ack_rx_pop) rx_unf <= 1'b1;
      end
    end
  end

endmodule
